// File: rtl/imp_frame_seq.sv
// Frame sequencer for one image-move DMA channel: latches the ROI configuration on a
// start edge, then issues one line request per row with a bounded number in flight.
module imp_frame_seq #(
  parameter int unsigned BPP       = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned BYTES_W  = 16 + $clog2(BPP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  cfg_baddr,
  input  logic [31:0]        cfg_pitch,
  input  logic [15:0]        cfg_hsize,
  input  logic [15:0]        cfg_vsize,
  input  logic [7:0]         cfg_minx,
  input  logic [7:0]         cfg_miny,
  input  logic               cfg_st,
  output logic               line_req_valid,
  input  logic               line_req_ready,
  output logic [ADDR_W-1:0]  line_req_addr,
  output logic [BYTES_W-1:0] line_req_bytes,
  input  logic               line_done,
  output logic               busy,
  output logic               done,
  output logic [15:0]        line_cnt,
  output logic               err
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 st_prev_q, st_prev_d;
  logic [ADDR_W-1:0]    baddr_q, baddr_d;
  logic [31:0]          pitch_q, pitch_d;
  logic [15:0]          hsize_q, hsize_d;
  logic [15:0]          vsize_q, vsize_d;
  logic [7:0]           minx_q, minx_d;
  logic [7:0]           miny_q, miny_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BYTES_W-1:0]   bytes_q, bytes_d;
  logic [15:0]          rows_q, rows_d;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic [15:0]          line_cnt_q, line_cnt_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;

  logic start_c, hs_c, ld_ok_c, spur_c;

  // A line_done with nothing outstanding (which covers IDLE) is a protocol error.
  assign start_c = cfg_st & ~st_prev_q;
  assign hs_c    = valid_q & line_req_ready;
  assign ld_ok_c = line_done & (outst_q != '0);
  assign spur_c  = line_done & ~ld_ok_c;

  always_comb begin
    state_d    = state_q;
    st_prev_d  = cfg_st;
    baddr_d    = baddr_q;
    pitch_d    = pitch_q;
    hsize_d    = hsize_q;
    vsize_d    = vsize_q;
    minx_d     = minx_q;
    miny_d     = miny_q;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    rows_d     = rows_q;
    outst_d    = outst_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          baddr_d    = cfg_baddr;
          pitch_d    = cfg_pitch;
          hsize_d    = cfg_hsize;
          vsize_d    = cfg_vsize;
          minx_d     = cfg_minx;
          miny_d     = cfg_miny;
          line_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        addr_d  = baddr_q + ADDR_W'(48'(miny_q) * 48'(pitch_q))
                + ADDR_W'(minx_q) * ADDR_W'(BPP);
        bytes_d = BYTES_W'(hsize_q) * BYTES_W'(BPP);
        rows_d  = vsize_q;
        state_d = (hsize_q == '0 || vsize_q == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (hs_c) begin
          addr_d = addr_q + ADDR_W'(pitch_q);
          rows_d = rows_q - 16'd1;
          if (rows_q == 16'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    unique case ({hs_c, ld_ok_c})
      2'b10:   outst_d = outst_q + OUTST_W'(1);
      2'b01:   outst_d = outst_q - OUTST_W'(1);
      default: ;
    endcase

    if (ld_ok_c && line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
    if (spur_c) err_d = 1'b1;

    // Drain exit looks at the post-update count so done follows the last line_done by one cycle.
    if (state_q == S_DRAIN && outst_d == '0 && rows_q == '0) state_d = S_DONE;

    busy_d  = (state_d == S_CALC) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_ISSUE) && (rows_d != '0) && (outst_d < OUTST_W'(MAX_OUTST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      st_prev_q  <= 1'b0;
      baddr_q    <= '0;
      pitch_q    <= '0;
      hsize_q    <= '0;
      vsize_q    <= '0;
      minx_q     <= '0;
      miny_q     <= '0;
      addr_q     <= '0;
      bytes_q    <= '0;
      rows_q     <= '0;
      outst_q    <= '0;
      line_cnt_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_prev_q  <= st_prev_d;
      baddr_q    <= baddr_d;
      pitch_q    <= pitch_d;
      hsize_q    <= hsize_d;
      vsize_q    <= vsize_d;
      minx_q     <= minx_d;
      miny_q     <= miny_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      rows_q     <= rows_d;
      outst_q    <= outst_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign line_req_valid = valid_q;
  assign line_req_addr  = addr_q;
  assign line_req_bytes = bytes_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign line_cnt       = line_cnt_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imp_frame_seq.sv
// Bench for imp_frame_seq: a count-based frame model checked every cycle, with random
// ready/line_done timing and literal expectations for the planned scenarios.
module tb_imp_frame_seq;

  localparam int BPP       = 4;
  localparam int MAX_OUTST = 2;
  localparam int ADDR_W    = 32;
  localparam int BYTES_W   = 16 + $clog2(BPP);

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  cfg_baddr;
  logic [31:0]        cfg_pitch;
  logic [15:0]        cfg_hsize, cfg_vsize;
  logic [7:0]         cfg_minx, cfg_miny;
  logic               cfg_st;
  logic               line_req_valid, line_req_ready;
  logic [ADDR_W-1:0]  line_req_addr;
  logic [BYTES_W-1:0] line_req_bytes;
  logic               line_done, busy, done, err;
  logic [15:0]        line_cnt;

  imp_frame_seq #(.BPP(BPP), .MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_baddr(cfg_baddr), .cfg_pitch(cfg_pitch), .cfg_hsize(cfg_hsize),
    .cfg_vsize(cfg_vsize), .cfg_minx(cfg_minx), .cfg_miny(cfg_miny), .cfg_st(cfg_st),
    .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
    .line_req_addr(line_req_addr), .line_req_bytes(line_req_bytes),
    .line_done(line_done), .busy(busy), .done(done), .line_cnt(line_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: frame progress as counts of issued and completed lines.
  bit          m_busy, m_calc, m_done, m_valid, m_err, m_st_prev;
  int          m_issued, m_completed, m_h, m_v, m_minx, m_miny;
  logic [15:0] m_line_cnt;
  logic [31:0] m_base, m_pitch;

  int          ld_q[$];
  logic [31:0] hs_log[$];
  int          ld_delay = 3;
  bit          rand_ready = 1'b0;
  bit          force_ld = 1'b0;
  int          done_count, last_done_cyc, last_ld_cyc, start_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return 32'(64'(m_base) + 64'(m_miny + i) * 64'(m_pitch) + 64'(m_minx * BPP));
  endfunction

  task automatic model_edge(input bit st_s, input bit rdy, input bit ld, input bit rst_s,
                            input logic [31:0] addr_s);
    bit hs, start, good, spur, idle;
    if (rst_s) begin
      m_busy = 0; m_calc = 0; m_done = 0; m_valid = 0; m_err = 0; m_st_prev = 0;
      m_issued = 0; m_completed = 0; m_line_cnt = '0;
      ld_q.delete();
      return;
    end
    hs    = m_valid && rdy;
    start = st_s && !m_st_prev;
    m_st_prev = st_s;
    good  = ld && (m_issued - m_completed) > 0;
    spur  = ld && !good;
    idle  = !m_busy && !m_done;
    m_done = 0;
    if (hs) begin
      hs_log.push_back(addr_s);
      ld_q.push_back(cyc + ld_delay);
    end
    if (idle) begin
      if (start) begin
        m_base = cfg_baddr; m_pitch = cfg_pitch; m_h = int'(cfg_hsize); m_v = int'(cfg_vsize);
        m_minx = int'(cfg_minx); m_miny = int'(cfg_miny);
        m_busy = 1; m_calc = 1; m_issued = 0; m_completed = 0; m_line_cnt = '0; m_err = 0;
      end
    end else if (m_calc) begin
      m_calc = 0;
      if (m_h == 0 || m_v == 0) begin m_busy = 0; m_done = 1; end
    end else if (m_busy) begin
      if (hs) m_issued++;
      if (good) m_completed++;
      if (m_issued == m_v && m_completed == m_v) begin m_busy = 0; m_done = 1; end
    end
    if (good) begin
      last_ld_cyc = cyc;
      if (m_line_cnt != 16'hFFFF) m_line_cnt = m_line_cnt + 16'd1;
    end
    if (spur) m_err = 1;
    m_valid = m_busy && !m_calc && m_issued < m_v && (m_issued - m_completed) < MAX_OUTST;
  endtask

  task automatic compare();
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("valid", 64'(line_req_valid), 64'(m_valid));
    chk("line_cnt", 64'(line_cnt), 64'(m_line_cnt));
    chk("err", 64'(err), 64'(m_err));
    if (m_valid) begin
      chk("addr", 64'(line_req_addr), 64'(exp_addr(m_issued)));
      chk("bytes", 64'(line_req_bytes), 64'(m_h * BPP));
    end
    if (done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare outputs.
  task automatic step();
    bit st_s, rdy, ld, rst_s;
    logic [31:0] addr_s;
    line_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    line_done = force_ld;
    if (ld_q.size() > 0 && ld_q[0] <= cyc) begin
      line_done = 1'b1;
      void'(ld_q.pop_front());
    end
    st_s = cfg_st; rdy = line_req_ready; ld = line_done; rst_s = rst; addr_s = line_req_addr;
    @(posedge clk);
    #1;
    model_edge(st_s, rdy, ld, rst_s, addr_s);
    cyc++;
    compare();
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [31:0] p, input int h, input int v,
                             input int mx, input int my, input int dly, input bit rr, input bit hold);
    cfg_st = 1'b0;
    step();
    cfg_baddr = b; cfg_pitch = p; cfg_hsize = 16'(h); cfg_vsize = 16'(v);
    cfg_minx = 8'(mx); cfg_miny = 8'(my);
    ld_delay = dly; rand_ready = rr;
    hs_log.delete();
    done_count = 0;
    start_cyc = cyc;
    cfg_st = 1'b1;
    step();
    if (!hold) cfg_st = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || m_done) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic run_frame(input logic [31:0] b, input logic [31:0] p, input int h, input int v,
                           input int mx, input int my, input int dly, input bit rr);
    start_frame(b, p, h, v, mx, my, dly, rr, 1'b0);
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1; cfg_st = 1'b0; line_req_ready = 1'b1; line_done = 1'b0;
    cfg_baddr = '0; cfg_pitch = '0; cfg_hsize = '0; cfg_vsize = '0; cfg_minx = '0; cfg_miny = '0;
    step(); step();
    chk("reset_valid", 64'(line_req_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_addr", 64'(line_req_addr), 64'd0);
    rst = 1'b0;
    step();

    // Basic frame
    run_frame(32'h0010_0000, 32'd16, 4, 6, 0, 0, 3, 1'b0);
    chk("basic_nreq", 64'(hs_log.size()), 64'd6);
    for (int i = 0; i < hs_log.size(); i++) chk("basic_addr", 64'(hs_log[i]), 64'(32'h0010_0000 + 32'(16 * i)));
    chk("basic_line_cnt", 64'(line_cnt), 64'd6);
    chk("basic_done_count", 64'(done_count), 64'd1);
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_done_lat", 64'(last_done_cyc - last_ld_cyc), 64'd1);

    // ROI offset
    run_frame(32'h0000_1000, 32'd64, 4, 2, 2, 3, 3, 1'b0);
    chk("roi_nreq", 64'(hs_log.size()), 64'd2);
    if (hs_log.size() == 2) begin
      chk("roi_addr0", 64'(hs_log[0]), 64'h10C8);
      chk("roi_addr1", 64'(hs_log[1]), 64'h1108);
    end

    // Backpressure with long line latency
    run_frame(32'h2000_0000, 32'd128, 8, 6, 1, 1, 20, 1'b1);
    chk("bp_nreq", 64'(hs_log.size()), 64'd6);
    chk("bp_done_count", 64'(done_count), 64'd1);
    chk("bp_done_lat", 64'(last_done_cyc - last_ld_cyc), 64'd1);

    // Degenerate sizes
    run_frame(32'h0000_4000, 32'd16, 4, 0, 0, 0, 3, 1'b0);
    chk("v0_nreq", 64'(hs_log.size()), 64'd0);
    chk("v0_done_lat", 64'(last_done_cyc - start_cyc), 64'd2);
    run_frame(32'h0000_4000, 32'd16, 0, 3, 0, 0, 3, 1'b0);
    chk("h0_nreq", 64'(hs_log.size()), 64'd0);
    chk("h0_done_count", 64'(done_count), 64'd1);

    // Start held high across done
    start_frame(32'h0000_5000, 32'd32, 2, 3, 0, 0, 2, 1'b0, 1'b1);
    wait_idle();
    for (int i = 0; i < 10; i++) step();
    chk("hold_done_count", 64'(done_count), 64'd1);
    chk("hold_nreq", 64'(hs_log.size()), 64'd3);

    // Retoggle and config change while busy
    start_frame(32'h0000_6000, 32'd32, 2, 4, 0, 0, 20, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    cfg_baddr = 32'hDEAD_0000; cfg_vsize = 16'd9;
    cfg_st = 1'b1; step();
    cfg_st = 1'b0; step();
    wait_idle();
    chk("retrig_done_count", 64'(done_count), 64'd1);
    chk("retrig_nreq", 64'(hs_log.size()), 64'd4);

    // Handshake and line_done coinciding
    run_frame(32'h0000_3000, 32'd32, 2, 5, 0, 0, 1, 1'b0);
    chk("simul_line_cnt", 64'(line_cnt), 64'd5);
    chk("simul_nreq", 64'(hs_log.size()), 64'd5);

    // Spurious line_done in idle, cleared by the next start
    force_ld = 1'b1; step(); force_ld = 1'b0;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_line_cnt", 64'(line_cnt), 64'd5);
    start_frame(32'h0000_7000, 32'd16, 1, 1, 0, 0, 2, 1'b0, 1'b0);
    chk("spur_err_clr", 64'(err), 64'd0);
    wait_idle();

    // Address wrap, full frame
    run_frame(32'hFFFF_FFF0, 32'd16, 4, 3, 0, 0, 3, 1'b0);
    chk("wrap_nreq", 64'(hs_log.size()), 64'd3);
    if (hs_log.size() == 3) begin
      chk("wrap_addr0", 64'(hs_log[0]), 64'hFFFF_FFF0);
      chk("wrap_addr1", 64'(hs_log[1]), 64'h0);
      chk("wrap_addr2", 64'(hs_log[2]), 64'h10);
    end

    // Reset mid-frame after the second handshake
    start_frame(32'hFFFF_FFF0, 32'd16, 4, 3, 0, 0, 10, 1'b0, 1'b0);
    n = 0;
    while (hs_log.size() < 2 && n < 100) begin step(); n++; end
    chk("rst_mid_reached", 64'(hs_log.size()), 64'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_valid", 64'(line_req_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_line_cnt", 64'(line_cnt), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    chk("rst_mid_addr", 64'(line_req_addr), 64'd0);
    chk("rst_mid_bytes", 64'(line_req_bytes), 64'd0);
    for (int i = 0; i < 3; i++) step();

    // Random frames
    for (int f = 0; f < 20; f++) begin
      int v;
      v = $urandom_range(0, 10);
      run_frame($urandom, $urandom, $urandom_range(0, 20), v, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(1, 20), 1'b1);
      chk("rand_done_count", 64'(done_count), 64'd1);
      chk("rand_nreq", 64'(hs_log.size()), 64'(m_h == 0 ? 0 : v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imp_frame_seq.md
Name: imp_frame_seq

Overview:
- Frame sequencer for one image-move DMA channel (WR or RD); one instance per channel, placed between the AXI-Lite register file outputs (BADDR, PITCH, HSIZE, VSIZE, COOR_MINX/MINY, ST) and the AXI burst master.
- On a rising edge of the ST register bit, latches the configuration and computes the ROI start address.
- Issues one line request per row to the burst master, keeping a bounded number of lines outstanding.
- Reports busy, done and error status.

Parameters:
- BPP, 4: bytes per pixel; power of two, 1..8.
- MAX_OUTST, 2: maximum line requests outstanding at the burst master, 1..15.
- ADDR_W, 32: address width; equals the AXI address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- cfg_baddr  in  ADDR_W  frame base address.
- cfg_pitch  in  32  line pitch in bytes.
- cfg_hsize  in  16  ROI width in pixels.
- cfg_vsize  in  16  ROI height in lines.
- cfg_minx  in  8  ROI x origin in pixels.
- cfg_miny  in  8  ROI y origin in lines.
- cfg_st  in  1  start register bit (level); the sequencer edge-detects it.
- line_req_valid  out  1  line request valid.
- line_req_ready  in  1  burst master accepts the request.
- line_req_addr  out  ADDR_W  first byte address of the line.
- line_req_bytes  out  16+log2(BPP)  line length in bytes = hsize*BPP.
- line_done  in  1  one-cycle pulse; the burst master finished one line.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse when the frame completes.
- line_cnt  out  16  number of lines completed in the current frame.
- err  out  1  sticky protocol error.

Behaviour:
- Reset state: state=IDLE; all outputs 0; st_d=0; outstanding=0.
- Start event: start = cfg_st & ~st_d, where st_d is cfg_st registered.
  - Acted on only in IDLE; ignored in every other state.
  - cfg_st held high triggers exactly one frame.
- IDLE -> CALC on start event:
  - latch all cfg_* into shadow registers;
  - clear line_cnt and err;
  - set busy.
- CALC, one cycle:
  - addr_cur = baddr + miny*pitch + minx*BPP, computed mod 2^ADDR_W (wrap silently);
  - bytes = hsize*BPP;
  - rows_left = vsize.
  - If hsize==0 or vsize==0, go to DONE with no requests issued. Otherwise go to ISSUE.
- ISSUE:
  - line_req_valid=1 whenever outstanding < MAX_OUTST and rows_left != 0.
  - addr and bytes are held stable while valid & ~ready; valid never drops without a handshake.
  - On handshake: addr_cur += pitch (mod 2^ADDR_W); rows_left--; outstanding++.
  - When rows_left reaches 0, go to DRAIN.
- DRAIN: wait until outstanding==0 and rows_left==0, then go to DONE.
- Outstanding counter, every cycle:
  - handshake and line_done in the same cycle: unchanged;
  - line_done alone: decrement;
  - handshake alone: increment.
- line_cnt: increments on each line_done while busy; saturates at 0xFFFF.
- Spurious line_done (outstanding==0, or state IDLE):
  - set err; counters unchanged;
  - no underflow; no state change.
- DONE, one cycle:
  - done=1; busy=0; go to IDLE.
  - A start event seen in the same cycle is ignored; the first start accepted is one detected in IDLE.
- Configuration inputs are sampled only at the start event; changes during a frame have no effect.
- Latency:
  - start edge on cycle N: busy rises on N+1, first valid on N+2;
  - last line_done on cycle M: done pulses on M+1.
- Reset mid-frame: returns immediately to the reset state. Requests already issued are abandoned; the burst master is reset by the same rst.

Test Plan:
- Basic frame: baddr=0x0010_0000, pitch=16, hsize=4, vsize=6, minx=0, miny=0, BPP=4, ready tied 1, line_done 3 cycles after each handshake -> 6 requests at 0x0010_0000, 0x...10, ..., 0x...50; bytes=16; line_cnt=6; one done pulse; busy low after.
- ROI offset: minx=2, miny=3, pitch=64, base=0x1000 -> first addr 0x10C8, next 0x1108; vsize=2 gives exactly 2 requests.
- Backpressure and outstanding: MAX_OUTST=2, ready random 50%, line_done delayed 20 cycles -> never more than 2 handshakes ahead of line_done; addr/bytes stable while valid & ~ready; done exactly after the 6th line_done.
- Degenerate and retrigger: vsize=0 -> done 2 cycles after start, no valid; cfg_st held high across done -> no second frame; toggle 0->1 while busy -> ignored.
- Simultaneous/error: handshake and line_done in the same cycle -> outstanding unchanged; line_done in IDLE -> err=1, cleared by next start.
- Wrap and reset: base=0xFFFF_FFF0, pitch=16, vsize=3 -> addrs 0xFFFF_FFF0, 0x0000_0000, 0x0000_0010; assert rst after the 2nd handshake -> next cycle all outputs 0, state IDLE.
